// File: rtl/seg_scan_controller.sv
// seg_scan_controller: multiplexed common-anode 7-segment scanner.
// Frame-shadowed inputs, PWM brightness, blink/blank masks, dead cycle.
module seg_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 32768,
    parameter int PWM_BITS     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] seg_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    localparam int SW = $clog2(DIGIT_CYCLES);
    localparam int FW = $clog2(BLINK_FRAMES) + 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGIT_CYCLES - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        g = 7'h7F;
        unique case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
        endcase
        return g;
    endfunction

    logic [SW-1:0]                slot_q, slot_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic [FW-1:0]                frame_q, frame_d;
    logic                         blink_phase_q, blink_phase_d;
    logic [NUM_DIGITS-1:0][3:0]   data_sh_q, data_sh_d;
    logic [NUM_DIGITS-1:0]        dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]        blank_sh_q, blank_sh_d;
    logic [NUM_DIGITS-1:0]        blink_sh_q, blink_sh_d;
    logic [PWM_BITS-1:0]          bright_sh_q, bright_sh_d;
    logic                         load_pending_q, load_pending_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic [6:0]                   seg_q, seg_d;
    logic                         dp_q, dp_d;
    logic                         fs_q, fs_d;
    logic                         slot_wrap, frame_wrap, load;
    logic                         visible, anode_on;

    // Scan counters, blink phase and once-per-frame shadow capture.
    always_comb begin
        slot_wrap      = (slot_q == SLOT_LAST);
        frame_wrap     = slot_wrap && (idx_q == '0);
        load           = load_pending_q || frame_wrap;
        load_pending_d = 1'b0;
        slot_d         = slot_wrap ? '0 : slot_q + SW'(1);
        idx_d          = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == '0) ? IDX_LAST : idx_q - IW'(1);
        end
        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        if (frame_wrap) begin
            if (frame_q == FRAME_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + FW'(1);
            end
        end
        data_sh_d   = data_sh_q;
        dp_sh_d     = dp_sh_q;
        blank_sh_d  = blank_sh_q;
        blink_sh_d  = blink_sh_q;
        bright_sh_d = bright_sh_q;
        if (load) begin
            data_sh_d   = seg_data;
            dp_sh_d     = dp_in;
            blank_sh_d  = blank_mask;
            blink_sh_d  = blink_mask;
            bright_sh_d = brightness;
        end
    end

    // Pin decode for the current slot; registered one cycle later.
    always_comb begin
        visible  = !blank_sh_q[idx_q] && !(blink_sh_q[idx_q] && blink_phase_q);
        anode_on = visible && (slot_q != '0)
                   && (slot_q[PWM_BITS-1:0] <= bright_sh_q);
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (anode_on) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph(data_sh_q[idx_q]);
            dp_d        = ~dp_sh_q[idx_q];
        end
        fs_d = (idx_q == IDX_LAST) && (slot_q == '0) && !load_pending_q;
    end

    // State and output registers, all cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q         <= '0;
            idx_q          <= IDX_LAST;
            frame_q        <= '0;
            blink_phase_q  <= 1'b0;
            data_sh_q      <= '0;
            dp_sh_q        <= '0;
            blank_sh_q     <= '1;
            blink_sh_q     <= '0;
            bright_sh_q    <= '0;
            load_pending_q <= 1'b1;
            an_q           <= '1;
            seg_q          <= 7'h7F;
            dp_q           <= 1'b1;
            fs_q           <= 1'b0;
        end else begin
            slot_q         <= slot_d;
            idx_q          <= idx_d;
            frame_q        <= frame_d;
            blink_phase_q  <= blink_phase_d;
            data_sh_q      <= data_sh_d;
            dp_sh_q        <= dp_sh_d;
            blank_sh_q     <= blank_sh_d;
            blink_sh_q     <= blink_sh_d;
            bright_sh_q    <= bright_sh_d;
            load_pending_q <= load_pending_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            fs_q           <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb_seg_scan_controller: scoreboard bench with a cycle-count reference model.
// Expected pin states are queued per clock edge and checked on the falling edge.
module tb_seg_scan_controller;
    localparam int N  = 4;
    localparam int DC = 8;
    localparam int PB = 2;
    localparam int BF = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4*N-1:0] seg_data = '0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  blank_mask = '0;
    logic [N-1:0]  blink_mask = '0;
    logic [PB-1:0] brightness = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          frame_start;

    seg_scan_controller #(
        .NUM_DIGITS  (N),
        .DIGIT_CYCLES(DC),
        .PWM_BITS    (PB),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_data   (seg_data),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         fs;
    } out_t;

    out_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_pops = 0;

    logic [6:0] glyph_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Reference model: state is just the number of edges since reset release.
    initial begin : model
        int            k;
        int            slot, pos, idx, f, ph;
        bit            on;
        logic [4*N-1:0] m_data;
        logic [N-1:0]  m_dp, m_blank, m_blink, one;
        logic [PB-1:0] m_bright;
        out_t          e;
        one = 1;
        k = 0;
        m_data = '0; m_dp = '0; m_blank = '1; m_blink = '0; m_bright = '0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                exp_q.delete();
                k = 0;
                m_data = '0; m_dp = '0; m_blank = '1; m_blink = '0; m_bright = '0;
            end else begin
                slot = k % DC;
                pos  = (k / DC) % N;
                idx  = N - 1 - pos;
                f    = k / (DC * N);
                ph   = (f / BF) % 2;
                on   = !m_blank[idx] && !(m_blink[idx] && ph == 1)
                       && slot != 0 && (slot % (1 << PB)) <= int'(m_bright);
                e.an  = on ? ~(one << idx) : '1;
                e.seg = on ? glyph_tbl[m_data[4*idx +: 4]] : 7'h7F;
                e.dp  = on ? ~m_dp[idx] : 1'b1;
                e.fs  = (slot == 0) && (pos == 0) && (k != 0);
                exp_q.push_back(e);
                if (k == 0 || (k + 1) % (DC * N) == 0) begin
                    m_data = seg_data; m_dp = dp_in; m_blank = blank_mask;
                    m_blink = blink_mask; m_bright = brightness;
                end
                k++;
            end
        end
    end

    // Monitor: compare each registered output cycle against the scoreboard.
    initial begin : monitor
        out_t got, e;
        forever begin
            @(negedge clk);
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_pops++;
                got.an = an; got.seg = seg; got.dp = dp; got.fs = frame_start;
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL out t=%0t got an=%b seg=%h dp=%b fs=%b want an=%b seg=%h dp=%b fs=%b",
                             $time, got.an, got.seg, got.dp, got.fs, e.an, e.seg, e.dp, e.fs);
                end
                n_checks++;
                if ($countones(~an) > 1) begin
                    n_fail++;
                    $display("FAIL one_hot t=%0t got an=%b want at most one low", $time, an);
                end
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_in(input logic [4*N-1:0] d, input logic [N-1:0] dpv,
                          input logic [N-1:0] bl, input logic [N-1:0] bk,
                          input logic [PB-1:0] br);
        seg_data = d; dp_in = dpv; blank_mask = bl; blink_mask = bk; brightness = br;
    endtask

    task automatic check_reset(input string name);
        n_checks++;
        if (an !== '1 || seg !== 7'h7F || dp !== 1'b1 || frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got an=%b seg=%h dp=%b fs=%b want an=1111 seg=7f dp=1 fs=0",
                     name, an, seg, dp, frame_start);
        end
    endtask

    task automatic mid_slot_reset(input int hold);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_reset("async_reset");
        wait_neg(hold);
        reset = 1'b0;
    endtask

    // Stimulus: directed scenarios followed by randomized input changes.
    initial begin : stim
        set_in(16'h1234, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        wait_neg(3);
        check_reset("reset_state");
        reset = 1'b0;
        wait_neg(40);
        set_in(16'hABCF, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        wait_neg(80);
        set_in(16'h5678, 4'b0000, 4'b0000, 4'b0000, 2'd0);
        wait_neg(40);
        set_in(16'h9ABC, 4'b0000, 4'b0000, 4'b0000, 2'd2);
        wait_neg(40);
        set_in(16'hDEF0, 4'b0000, 4'b1000, 4'b0001, 2'd3);
        wait_neg(260);
        set_in(16'h1234, 4'b0100, 4'b0000, 4'b0000, 2'd3);
        wait_neg(70);
        mid_slot_reset(3);
        wait_neg(70);
        for (int i = 0; i < 60; i++) begin
            wait_neg($urandom_range(1, 40));
            set_in(16'($urandom), 4'($urandom),
                   4'($urandom & $urandom & $urandom), 4'($urandom),
                   2'($urandom));
            if (i % 20 == 10) mid_slot_reset($urandom_range(1, 4));
        end
        wait_neg(70);
        n_checks++;
        if (n_pops < 1500) begin
            n_fail++;
            $display("FAIL coverage got %0d checked cycles want at least 1500", n_pops);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
